alu_share_arb: RTL and testbench

//   Shares one ALU instance (32-bit, 4-bit op) between two requesters.
//   Two-way arbiter: round-robin or fixed priority. Operands and op are

---
 rtl/alu_share_arb.sv | 162 ++++++++++++++++
 tb/tb_alu_share_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Two-requester front end for a single 32-bit ALU: arbitrate, latch operands,
// execute one cycle, then hold the registered result until the owner takes it.
module alu_share_arb #(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [31:0]      req0_src0,
  input  logic [31:0]      req0_src1,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [31:0]      req1_src0,
  input  logic [31:0]      req1_src1,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_res,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_res,
  output logic             rsp1_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done,
  output logic [1:0]       dbg_state
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; ready never depends on anything but state and the valids.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      src0_q, src0_d;
  logic [31:0]      src1_q, src1_d;
  logic [31:0]      res_q, res_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic             gnt_valid;
  logic             gnt_sel;
  logic             rsp_fire;
  logic [31:0]      alu_res;
  logic             alu_err;
  logic [4:0]       shamt;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    shamt   = src1_q[4:0];
    case (op_q)
      4'h0: alu_res = src0_q + src1_q;
      4'h1: alu_res = src0_q - src1_q;
      4'h2: alu_res = {31'd0, $signed(src0_q) < $signed(src1_q)};
      4'h3: alu_res = {31'd0, src0_q < src1_q};
      4'h4: alu_res = src0_q & src1_q;
      4'h5: alu_res = src0_q | src1_q;
      4'h6: alu_res = ~(src0_q | src1_q);
      4'h7: alu_res = src0_q ^ src1_q;
      4'h8: alu_res = src0_q << shamt;
      4'h9: alu_res = src0_q >> shamt;
      4'hA: alu_res = 32'($signed(src0_q) >>> shamt);
      4'hB: alu_res = src1_q;
      default: alu_err = 1'b1;
    endcase
  end

  // On a tie the round-robin pointer favours whoever was not served last.
  always_comb begin
    gnt_valid = (state_q == IDLE) && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) gnt_sel = RR_EN ? ~last_grant_q : 1'b0;
    else                          gnt_sel = req1_valid;
    rsp_fire = owner_q ? rsp1_ready : rsp0_ready;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    src0_d       = src0_q;
    src1_d       = src1_q;
    res_d        = res_q;
    err_d        = err_q;
    ops_done_d   = ops_done_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          req0_ready   = ~gnt_sel;
          req1_ready   = gnt_sel;
          op_d         = gnt_sel ? req1_op   : req0_op;
          src0_d       = gnt_sel ? req1_src0 : req0_src0;
          src1_d       = gnt_sel ? req1_src1 : req0_src1;
          owner_d      = gnt_sel;
          last_grant_d = gnt_sel;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_res;
        err_d   = alu_err;
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (rsp_fire) begin
          ops_done_d = ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      src0_q       <= '0;
      src1_q       <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      src0_q       <= src0_d;
      src1_q       <= src1_d;
      res_q        <= res_d;
      err_q        <= err_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign rsp0_res  = res_q;
  assign rsp1_res  = res_q;
  assign rsp0_err  = err_q;
  assign rsp1_err  = err_q;
  assign busy      = (state_q != IDLE);
  assign ops_done  = ops_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a round-robin instance plus a fixed-priority
// instance with a narrow counter, both fed from the same request/response inputs.
module tb_alu_share_arb;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_src0, req0_src1, req1_src0, req1_src1;
  logic        rsp0_ready, rsp1_ready;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy;
  logic [31:0] rsp0_res, rsp1_res;
  logic [15:0] ops_done;
  logic [1:0]  dbg_state;

  logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp0_err, f_rsp1_err, f_busy;
  logic [31:0] f_rsp0_res, f_rsp1_res;
  logic [3:0]  f_ops_done;
  logic [1:0]  f_dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          who;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  alu_share_arb #(.RR_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src0(req0_src0), .req0_src1(req0_src1),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src0(req1_src0), .req1_src1(req1_src1),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res), .rsp1_err(rsp1_err),
    .busy(busy), .ops_done(ops_done), .dbg_state(dbg_state)
  );

  alu_share_arb #(.RR_EN(1'b0), .CNT_W(4)) dut_f (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_op(req0_op),
    .req0_src0(req0_src0), .req0_src1(req0_src1),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_op(req1_op),
    .req1_src0(req1_src0), .req1_src1(req1_src1),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(f_rsp0_res), .rsp0_err(f_rsp0_err),
    .rsp1_valid(f_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(f_rsp1_res), .rsp1_err(f_rsp1_err),
    .busy(f_busy), .ops_done(f_ops_done), .dbg_state(f_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // driver: one complete operation on requester 'who'
  task automatic run_op(input int who, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output logic err, output int lat);
    int  n;
    logic got;
    @(negedge clk);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (who == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_src0 = a; req0_src1 = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_src0 = a; req1_src1 = b;
    end
    #1;
    n = 0;
    while (!(who == 0 ? req0_ready : req1_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_within_bound", 32'(n < 10), 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    // scribble over operands: the latched copy must be used
    req0_op = 4'($urandom_range(0, 15)); req0_src0 = $urandom; req0_src1 = $urandom;
    req1_op = 4'($urandom_range(0, 15)); req1_src0 = $urandom; req1_src1 = $urandom;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = (who == 0) ? rsp0_valid : rsp1_valid;
    end
    res = (who == 0) ? rsp0_res : rsp1_res;
    err = (who == 0) ? rsp0_err : rsp1_err;
    chk("other_rsp_valid_low", 32'((who == 0) ? rsp1_valid : rsp0_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] r;
  logic        e;
  int          lat;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req1_op = '0;
    req0_src0 = '0; req0_src1 = '0; req1_src0 = '0; req1_src1 = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    vecs[0]  = '{0, 4'h0, 32'd5,        32'd7,        32'd12,       1'b0};
    vecs[1]  = '{1, 4'h1, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{0, 4'h2, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vecs[3]  = '{1, 4'h3, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[4]  = '{0, 4'hA, 32'h80000000, 32'd4,        32'hF8000000, 1'b0};
    vecs[5]  = '{1, 4'h2, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[6]  = '{0, 4'h4, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
    vecs[7]  = '{1, 4'h5, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0};
    vecs[8]  = '{0, 4'h6, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{1, 4'h7, 32'h000000FF, 32'h000000F0, 32'h0000000F, 1'b0};
    vecs[10] = '{0, 4'h8, 32'd1,        32'h00000023, 32'd8,        1'b0};
    vecs[11] = '{1, 4'h9, 32'h80000000, 32'd31,       32'd1,        1'b0};
    vecs[12] = '{0, 4'hB, 32'h00001234, 32'h00005678, 32'h00005678, 1'b0};
    vecs[13] = '{1, 4'hD, 32'd5,        32'd7,        32'd0,        1'b1};
    vecs[14] = '{0, 4'h0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    vecs[15] = '{1, 4'hF, 32'd3,        32'd3,        32'd0,        1'b1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_res", rsp0_res, 32'd0);
    chk("rst_err", 32'(rsp0_err), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // ALU table, alternating requesters
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, r, e, lat);
      chk($sformatf("vec%0d_res", i), r, vecs[i].res);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_ops_done", i), 32'(ops_done), 32'(i + 1));
    end

    // both requesters valid every cycle
    do_reset();
    @(negedge clk);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'h0; req0_src0 = 32'd1; req0_src1 = 32'd2;
    req1_valid = 1'b1; req1_op = 4'h0; req1_src0 = 32'd3; req1_src1 = 32'd4;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk($sformatf("rr_req0_ready_k%0d", k), 32'(req0_ready), 32'((k % 3 == 0) && ((k / 3) % 2 == 0)));
      chk($sformatf("rr_req1_ready_k%0d", k), 32'(req1_ready), 32'((k % 3 == 0) && ((k / 3) % 2 == 1)));
      chk($sformatf("rr_rsp0_valid_k%0d", k), 32'(rsp0_valid), 32'((k % 3 == 2) && ((k / 3) % 2 == 0)));
      chk($sformatf("rr_rsp1_valid_k%0d", k), 32'(rsp1_valid), 32'((k % 3 == 2) && ((k / 3) % 2 == 1)));
      chk($sformatf("fp_req0_ready_k%0d", k), 32'(f_req0_ready), 32'(k % 3 == 0));
      chk($sformatf("fp_req1_ready_k%0d", k), 32'(f_req1_ready), 32'd0);
      if (k == 11) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("rr_ops_done", 32'(ops_done), 32'd4);
    chk("rr_last_res", rsp1_res, 32'd7);

    // response back-pressure on requester 0 while requester 1 waits
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'h0; req0_src0 = 32'd3; req0_src1 = 32'd4;
    #1 chk("bp_req0_accept", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req0_src0 = 32'd99;
    req1_valid = 1'b1; req1_op = 4'h1; req1_src0 = 32'd10; req1_src1 = 32'd3;
    @(negedge clk);
    chk("bp_exec_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_rsp0_valid_c%0d", i), 32'(rsp0_valid), 32'd1);
      chk($sformatf("bp_rsp0_res_c%0d", i), rsp0_res, 32'd7);
      chk($sformatf("bp_req1_ready_c%0d", i), 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    chk("bp_rsp0_valid_release", 32'(rsp0_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_state", 32'(dbg_state), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_req1_granted", 32'(req1_ready), 32'd1);
    chk("bp_ops_done", 32'(ops_done), 32'd5);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_req1_exec_no_rsp", 32'(rsp1_valid), 32'd0);
    @(negedge clk);
    chk("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("bp_rsp1_res", rsp1_res, 32'd7);
    @(posedge clk);
    #1;

    // reset while an op is executing
    do_reset();
    @(negedge clk);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'h0; req0_src0 = 32'd1; req0_src1 = 32'd1;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    chk("rst_exec_state", 32'(dbg_state), 32'd1);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    #1 chk("rst_exec_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_exec_no_rsp_c%0d", i), 32'(rsp0_valid | rsp1_valid), 32'd0);
      chk($sformatf("rst_exec_ops_done_c%0d", i), 32'(ops_done), 32'd0);
    end

    // counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_op(0, 4'h0, 32'(i), 32'd1, r, e, lat);
      chk($sformatf("wrap_res_%0d", i), r, 32'(i + 1));
      chk($sformatf("wrap_fp_ops_done_%0d", i), 32'(f_ops_done), 32'((i + 1) % 16));
    end
    chk("wrap_rr_ops_done", 32'(ops_done), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
